// File: rtl/gpio_port_n.sv
// gpio_port_n: parametrised GPIO port on the cartridge register bus.
//   Clk/Reset        : clock, synchronous active-low reset
//   Addr/DataWr/DataRd/En/Rd/Wr : register bus (Addr[5:2] reg, Addr[1:0] word)
//   PinIn            : raw async pad inputs, synchronised internally
//   PinOut/PinOe     : pad drive; the top level builds the tristate buffer
//   AltOut/AltOe     : peripheral drive, selected per pin by MODE
//   IntStatus        : registered OR of pending edge bits
//   IntReset         : one-cycle pulse clearing all pending bits
// Each pin is one gpio_port_n_lane instance; the top holds the arming
// counter, the read mux and IntStatus.

module gpio_port_n_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       armed,
  input  logic       wrHit,
  input  logic [3:0] regSel,
  input  logic       wrBit,
  input  logic       intReset,
  input  logic       pinIn,
  input  logic       altOut,
  input  logic       altOe,
  output logic       mode,
  output logic       ddr,
  output logic       data,
  output logic       pinSync,
  output logic       riseEn,
  output logic       fallEn,
  output logic       pend,
  output logic       pinOut,
  output logic       pinOe
);
  logic [SYNC_STAGES-1:0] syncQ;
  logic held, rise, fall, pendSet, pendClr;

  assign pinSync = syncQ[SYNC_STAGES-1];
  // Edges are masked until the sync chain and held copy hold real pad data.
  assign rise    = armed & pinSync & ~held;
  assign fall    = armed & ~pinSync & held;
  assign pendSet = (rise & riseEn) | (fall & fallEn);
  assign pendClr = (wrHit & wrBit & (regSel == 4'd9)) | intReset;

  assign pinOut = mode ? altOut : data;
  assign pinOe  = mode ? altOe  : ddr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      syncQ  <= '0;
      held   <= 1'b0;
      mode   <= 1'b0;
      ddr    <= 1'b0;
      data   <= 1'b0;
      riseEn <= 1'b0;
      fallEn <= 1'b0;
      pend   <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], pinIn};
      held  <= pinSync;
      // A fresh edge beats a simultaneous clear so it is never lost.
      pend  <= pendSet | (pend & ~pendClr);
      if (wrHit) begin
        case (regSel)
          4'd0: mode   <= wrBit;
          4'd1: ddr    <= wrBit;
          4'd2: data   <= wrBit;
          4'd4: if (wrBit) data <= 1'b1;
          4'd5: if (wrBit) data <= 1'b0;
          4'd6: if (wrBit) data <= ~data;
          4'd7: riseEn <= wrBit;
          4'd8: fallEn <= wrBit;
          default: ;
        endcase
      end
    end
  end
endmodule

module gpio_port_n #(
  parameter int          PINS        = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  PORT_ID     = 8'h01
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [5:0]      Addr,
  output logic [15:0]     DataRd,
  input  logic [15:0]     DataWr,
  input  logic            En,
  input  logic            Rd,
  input  logic            Wr,
  input  logic [PINS-1:0] PinIn,
  output logic [PINS-1:0] PinOut,
  output logic [PINS-1:0] PinOe,
  input  logic [PINS-1:0] AltOut,
  input  logic [PINS-1:0] AltOe,
  output logic            IntStatus,
  input  logic            IntReset
);
  localparam int W     = (PINS + 15) / 16;
  localparam int PW    = W * 16;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0] armCnt;
  logic             armed, wrEn;
  logic [PINS-1:0]  modeV, ddrV, dataV, pinV, riseEnV, fallEnV, pendV;
  logic [PW-1:0]    selVec;
  logic [15:0]      rdWord;
  // Rd carries no behaviour here; reads are purely combinational on En.
  logic [16:0]      unusedIn;

  assign unusedIn = {Rd, DataWr};
  assign wrEn     = En & Wr;
  assign armed    = (armCnt == ARM_MAX);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      armCnt    <= '0;
      IntStatus <= 1'b0;
    end else begin
      if (!armed) armCnt <= armCnt + 1'b1;
      IntStatus <= |pendV;
    end
  end

  for (genvar i = 0; i < PINS; i++) begin : gLane
    gpio_port_n_lane #(.SYNC_STAGES(SYNC_STAGES)) uLane (
      .clk      (Clk),
      .reset    (Reset),
      .armed    (armed),
      .wrHit    (wrEn && (Addr[1:0] == 2'(i / 16))),
      .regSel   (Addr[5:2]),
      .wrBit    (DataWr[i % 16]),
      .intReset (IntReset),
      .pinIn    (PinIn[i]),
      .altOut   (AltOut[i]),
      .altOe    (AltOe[i]),
      .mode     (modeV[i]),
      .ddr      (ddrV[i]),
      .data     (dataV[i]),
      .pinSync  (pinV[i]),
      .riseEn   (riseEnV[i]),
      .fallEn   (fallEnV[i]),
      .pend     (pendV[i]),
      .pinOut   (PinOut[i]),
      .pinOe    (PinOe[i])
    );
  end

  // Vectors are zero-padded to whole words so bits above PINS read 0.
  always_comb begin
    selVec = '0;
    case (Addr[5:2])
      4'd0:    selVec = PW'(modeV);
      4'd1:    selVec = PW'(ddrV);
      4'd2:    selVec = PW'(dataV);
      4'd3:    selVec = PW'(pinV);
      4'd7:    selVec = PW'(riseEnV);
      4'd8:    selVec = PW'(fallEnV);
      4'd9:    selVec = PW'(pendV);
      default: selVec = '0;
    endcase
    rdWord = 16'h0000;
    for (int w = 0; w < W; w++)
      if (Addr[1:0] == 2'(w)) rdWord = selVec[w*16 +: 16];
    if (Addr[5:2] == 4'd10 && Addr[1:0] == 2'd0) rdWord = {PORT_ID, 8'(PINS)};
    DataRd = En ? rdWord : 16'h0000;
  end
endmodule

// File: tb/tb_gpio_port_n.sv
// Directed bench for gpio_port_n: a 16-pin and a 20-pin instance on a shared
// bus (separate En per instance), expected values worked out by hand.
module tb_gpio_port_n;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] dataWr = '0;
  logic        wr = 1'b0, rd = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic        intReset1 = 1'b0, intReset2 = 1'b0;
  logic [15:0] dataRd1, dataRd2;
  logic [15:0] pinIn1 = '0, altOut1 = '0, altOe1 = '0, pinOut1, pinOe1;
  logic [19:0] pinIn2 = '1, altOut2 = '0, altOe2 = '0, pinOut2, pinOe2;
  logic        intStatus1, intStatus2;
  int checks = 0, failures = 0;

  localparam int R_MODE = 0, R_DDR = 1, R_DATA = 2, R_PIN = 3, R_SET = 4,
                 R_CLR = 5, R_TGL = 6, R_RISE = 7, R_FALL = 8, R_PEND = 9,
                 R_ID = 10, R_RSVD = 11;

  always #5 Clk = ~Clk;

  gpio_port_n #(.PINS(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .Addr(addr), .DataRd(dataRd1), .DataWr(dataWr),
    .En(en1), .Rd(rd), .Wr(wr), .PinIn(pinIn1), .PinOut(pinOut1), .PinOe(pinOe1),
    .AltOut(altOut1), .AltOe(altOe1), .IntStatus(intStatus1), .IntReset(intReset1));

  gpio_port_n #(.PINS(20)) dut2 (
    .Clk(Clk), .Reset(Reset), .Addr(addr), .DataRd(dataRd2), .DataWr(dataWr),
    .En(en2), .Rd(rd), .Wr(wr), .PinIn(pinIn2), .PinOut(pinOut2), .PinOe(pinOe2),
    .AltOut(altOut2), .AltOe(altOe2), .IntStatus(intStatus2), .IntReset(intReset2));

  function automatic logic [5:0] ra(input int r, input int w);
    return {r[3:0], w[1:0]};
  endfunction

  task automatic busWrite(input int sel, input int r, input int w, input logic [15:0] d);
    @(negedge Clk);
    addr = ra(r, w); dataWr = d; wr = 1'b1; en1 = (sel == 0); en2 = (sel == 1);
    @(negedge Clk);
    wr = 1'b0; en1 = 1'b0; en2 = 1'b0;
  endtask

  task automatic busRead(input int sel, input int r, input int w, output logic [15:0] d);
    addr = ra(r, w); rd = 1'b1; en1 = (sel == 0); en2 = (sel == 1);
    #1;
    d = (sel == 0) ? dataRd1 : dataRd2;
    rd = 1'b0; en1 = 1'b0; en2 = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    int regs[6] = '{R_MODE, R_DDR, R_DATA, R_RISE, R_FALL, R_PEND};
    repeat (3) @(negedge Clk);
    checks++; if (pinOe1 !== 16'h0000 || pinOut1 !== 16'h0000) begin failures++;
      $display("FAIL reset_pins oe=%h out=%h want 0000/0000", pinOe1, pinOut1); end
    // Release reset while the 20-pin port sits at all-ones and arm every rise enable.
    @(negedge Clk);
    Reset = 1'b1; addr = ra(R_RISE, 0); dataWr = 16'hFFFF; wr = 1'b1; en2 = 1'b1;
    @(negedge Clk);
    addr = ra(R_RISE, 1);
    @(negedge Clk);
    wr = 1'b0; en2 = 1'b0;
    repeat (6) @(negedge Clk);
    busRead(0, R_ID, 0, v);
    checks++; if (v !== 16'h0110) begin failures++; $display("FAIL reset_id got=%h want=0110", v); end
    foreach (regs[k]) begin
      busRead(0, regs[k], 0, v);
      checks++; if (v !== 16'h0000) begin failures++;
        $display("FAIL reset_reg%0d got=%h want=0000", regs[k], v); end
    end
    checks++; if (pinOe1 !== 16'h0000 || intStatus1 !== 1'b0) begin failures++;
      $display("FAIL reset_oe_int oe=%h int=%b want 0000/0", pinOe1, intStatus1); end
    busRead(1, R_PEND, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL arm_pend_w0 got=%h want=0000", v); end
    busRead(1, R_PEND, 1, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL arm_pend_w1 got=%h want=0000", v); end
    checks++; if (intStatus2 !== 1'b0) begin failures++; $display("FAIL arm_int got=%b want=0", intStatus2); end
    busRead(1, R_RISE, 1, v);
    checks++; if (v !== 16'h000F) begin failures++; $display("FAIL rise_w1_mask got=%h want=000F", v); end
    en1 = 1'b1; addr = ra(R_ID, 0); #1;
    en1 = 1'b0; #1;
    checks++; if (dataRd1 !== 16'h0000) begin failures++; $display("FAIL en_low_rd got=%h want=0000", dataRd1); end
  endtask

  task automatic test_set_clr_tgl;
    logic [15:0] v;
    busWrite(0, R_DDR, 0, 16'h00FF);
    busWrite(0, R_DATA, 0, 16'h1234);
    busWrite(0, R_SET, 0, 16'h0001);
    busRead(0, R_DATA, 0, v);
    checks++; if (v !== 16'h1235) begin failures++; $display("FAIL set got=%h want=1235", v); end
    busWrite(0, R_CLR, 0, 16'h0004);
    busWrite(0, R_TGL, 0, 16'h8000);
    busRead(0, R_DATA, 0, v);
    checks++; if (v !== 16'h9231) begin failures++; $display("FAIL data_rmw got=%h want=9231", v); end
    checks++; if (pinOe1 !== 16'h00FF) begin failures++; $display("FAIL pin_oe got=%h want=00FF", pinOe1); end
    checks++; if (pinOut1 !== 16'h9231) begin failures++; $display("FAIL pin_out got=%h want=9231", pinOut1); end
    busWrite(0, R_RSVD, 0, 16'hFFFF);
    busRead(0, R_RSVD, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reserved got=%h want=0000", v); end
  endtask

  task automatic test_alt_mode;
    altOut1 = 16'h0002; altOe1 = 16'h0003;
    busWrite(0, R_MODE, 0, 16'h0003);
    checks++; if (pinOut1 !== 16'h9232 || pinOe1 !== 16'h00FF) begin failures++;
      $display("FAIL alt_on out=%h oe=%h want 9232/00FF", pinOut1, pinOe1); end
    altOe1 = 16'h0001; #1;
    checks++; if (pinOe1[1:0] !== 2'b01) begin failures++;
      $display("FAIL alt_oe got=%b want=01", pinOe1[1:0]); end
    busWrite(0, R_MODE, 0, 16'h0000);
    checks++; if (pinOut1 !== 16'h9231 || pinOe1 !== 16'h00FF) begin failures++;
      $display("FAIL alt_off out=%h oe=%h want 9231/00FF", pinOut1, pinOe1); end
  endtask

  task automatic test_rise_irq;
    logic [15:0] v;
    busWrite(0, R_RISE, 0, 16'h0020);
    pinIn1[5] = 1'b1;
    @(negedge Clk);
    busRead(0, R_PIN, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL pin_lat1 got=%h want=0000", v); end
    @(negedge Clk);
    busRead(0, R_PIN, 0, v);
    checks++; if (v !== 16'h0020) begin failures++; $display("FAIL pin_lat2 got=%h want=0020", v); end
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL pend_lat2 got=%h want=0000", v); end
    @(negedge Clk);
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0020) begin failures++; $display("FAIL pend_lat3 got=%h want=0020", v); end
    checks++; if (intStatus1 !== 1'b0) begin failures++; $display("FAIL int_lat3 got=%b want=0", intStatus1); end
    @(negedge Clk);
    checks++; if (intStatus1 !== 1'b1) begin failures++; $display("FAIL int_lat4 got=%b want=1", intStatus1); end
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0020) begin failures++; $display("FAIL pend_no_rdclr got=%h want=0020", v); end
    busWrite(0, R_PEND, 0, 16'h0020);
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0000 || intStatus1 !== 1'b1) begin failures++;
      $display("FAIL pend_w1c pend=%h int=%b want 0000/1", v, intStatus1); end
    @(negedge Clk);
    checks++; if (intStatus1 !== 1'b0) begin failures++; $display("FAIL int_clear got=%b want=0", intStatus1); end
  endtask

  task automatic test_fall_intreset;
    logic [15:0] v;
    pinIn1[3] = 1'b1;
    repeat (4) @(negedge Clk);
    busWrite(0, R_FALL, 0, 16'h0008);
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL fall_pre got=%h want=0000", v); end
    pinIn1[3] = 1'b0;
    repeat (2) @(negedge Clk);
    intReset1 = 1'b1;   // lands on the same edge that records the fall
    @(negedge Clk);
    intReset1 = 1'b0;
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0008) begin failures++; $display("FAIL set_wins got=%h want=0008", v); end
    @(negedge Clk);
    checks++; if (intStatus1 !== 1'b1) begin failures++; $display("FAIL fall_int got=%b want=1", intStatus1); end
    intReset1 = 1'b1;
    @(negedge Clk);
    intReset1 = 1'b0;
    busRead(0, R_PEND, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL intreset_clr got=%h want=0000", v); end
  endtask

  task automatic test_wide_port;
    logic [15:0] v;
    busRead(1, R_ID, 0, v);
    checks++; if (v !== 16'h0114) begin failures++; $display("FAIL id20 got=%h want=0114", v); end
    busRead(1, R_ID, 1, v);
    checks++; if ((v & 16'hFFF0) !== 16'h0000) begin failures++; $display("FAIL id20_w1 got=%h want=000x", v); end
    busWrite(1, R_DDR, 1, 16'hFFFF);
    busRead(1, R_DDR, 1, v);
    checks++; if (v !== 16'h000F) begin failures++; $display("FAIL ddr_w1 got=%h want=000F", v); end
    busWrite(1, R_DDR, 2, 16'hFFFF);
    busRead(1, R_DDR, 2, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL ddr_w2 got=%h want=0000", v); end
    busRead(1, R_DDR, 0, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL ddr_w0 got=%h want=0000", v); end
    checks++; if (pinOe2 !== 20'hF0000) begin failures++; $display("FAIL oe20 got=%h want=F0000", pinOe2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_clr_tgl();
    test_alt_mode();
    test_rise_irq();
    test_fall_intreset();
    test_wide_port();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_port_n.md
Name: gpio_port_n

Overview:
- Parametrised general-purpose I/O port on the cartridge register bus; successor to the fixed 16-pin Mode/Ddr/Data port logic in the robot top levels.
- Supports a configurable pin count.
- Selects GPIO or peripheral (alternate) function per pin.
- Adds atomic set/clear/toggle, synchronised pin sampling, and per-pin rising/falling edge interrupts feeding the PrimaryInt IntStatus/IntReset pair.
- Top level owns the tristate buffers: PA[i] = PinOe[i] ? PinOut[i] : 1'bz.

Parameters:
- PINS, 16, number of pins, legal range 1..64; register words W = ceil(PINS/16).
- SYNC_STAGES, 2, input synchroniser depth, legal range 2..4.
- PORT_ID, 8'h01, value returned in the ID register.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- Addr  input  6  register select: Addr[5:2] selects the register, Addr[1:0] selects the 16-bit word.
- DataRd  output  16  read data.
- DataWr  input  16  write data.
- En  input  1  block select (upstream address decode).
- Rd  input  1  read qualifier.
- Wr  input  1  write strobe; one-Clk-cycle pulse, synchronous to Clk.
- PinIn  input  PINS  raw pad inputs (asynchronous).
- PinOut  output  PINS  pad output value.
- PinOe  output  PINS  pad output enable.
- AltOut  input  PINS  peripheral output value (e.g. XIR LED drive).
- AltOe  input  PINS  peripheral output enable.
- IntStatus  output  1  OR of all pending interrupt bits.
- IntReset  input  1  one-cycle pulse that clears all pending bits.

Behaviour:
- Register map (R = Addr[5:2]), one 16-bit word per register per word index:
  - 0 MODE (RW): 1 = alternate function.
  - 1 DDR (RW): 1 = output.
  - 2 DATA (RW).
  - 3 PIN (RO): synchronised input value.
  - 4 SET: write-1-to-set DATA.
  - 5 CLR: write-1-to-clear DATA.
  - 6 TGL: write-1-to-toggle DATA.
  - 7 RISE_EN (RW).
  - 8 FALL_EN (RW).
  - 9 PEND: write-1-to-clear.
  - 10 ID (RO): {PORT_ID, PINS[7:0]}.
  - 11..15: reserved; read 0, writes ignored.
- Writes happen when En & Wr are sampled high; the register updates at that clock edge, so the effect is visible on PinOut/PinOe on the next cycle.
- Word index >= W, or bits at or above PINS: read 0, writes ignored. SET/CLR/TGL/ID ignore writes of 0 bits.
- Read path:
  - DataRd is combinational from register state when En=1; DataRd=16'h0000 when En=0. Never x.
  - Reads have no side effects; PEND is not clear-on-read. Rd only qualifies reads and has no other effect.
- Pin drive:
  - PinOut[i] = MODE[i] ? AltOut[i] : DATA[i].
  - PinOe[i] = MODE[i] ? AltOe[i] : DDR[i].
- Input sampling:
  - PinIn passes through a SYNC_STAGES flop chain into S; PIN reads S.
  - H holds S delayed one cycle.
  - Rise[i] = S[i] & ~H[i]; Fall[i] = ~S[i] & H[i].
  - Edges are detected on all pins regardless of MODE/DDR, so an output pin can interrupt on its own transitions.
- Arming counter:
  - After Reset deasserts, ArmCnt counts SYNC_STAGES+1 cycles.
  - Edge detection is suppressed until ArmCnt saturates, so pins sitting at 1 do not produce false rises.
  - Reasserting Reset mid-count restarts the count.
- Pending bits:
  - PEND[i] is set by (Rise[i] & RISE_EN[i]) | (Fall[i] & FALL_EN[i]).
  - It is cleared by a PEND write-1 or by IntReset.
  - Set wins over clear in the same cycle, so the new edge is not lost.
  - Changing an enable does not clear an existing pending bit.
- IntStatus is registered: IntStatus = |PEND, so it follows PEND by one cycle.
- Reset (Reset=0 at a Clk edge): all registers, sync chain, H, ArmCnt, PEND and IntStatus go to 0. Result: PinOe=0 and PinOut=0 (MODE=0, DATA=0), i.e. all pins high-Z.
- Latency:
  - Pad edge to PIN visible: SYNC_STAGES cycles.
  - Pad edge to PEND set: SYNC_STAGES+1 cycles.
  - Pad edge to IntStatus: SYNC_STAGES+2 cycles.

Test Plan:
1. Reset, PINS=16 → read ID returns 16'h0110; read all RW registers = 0; PinOe = 16'h0000.
2. Write DDR=16'h00FF, DATA=16'h1234, then SET=16'h0001, CLR=16'h0004, TGL=16'h8000 → DATA reads 16'h9231; PinOe=16'h00FF; PinOut=16'h9231.
3. Write MODE=16'h0003 with AltOut=16'h0002, AltOe=16'h0003 → PinOut[1:0]=2'b10, PinOe[1:0]=2'b11. Write MODE=0 → pins revert to DATA/DDR the next cycle.
4. RISE_EN[5]=1, then PinIn[5] 0→1 → PIN[5]=1 after 2 cycles, PEND reads 16'h0020 after 3, IntStatus=1 after 4. Write PEND=16'h0020 → IntStatus=0 the following cycle.
5. PinIn[3] falls with FALL_EN[3]=1 in the same cycle as IntReset → PEND[3] remains 1.
6. PINS=20: word 1 ID/DDR bits 15:4 read 0; writes to word 2 are ignored. PinIn=all 1 across reset release with RISE_EN all 1 → no PEND set.
